// File: rtl/lcd_console.sv
`default_nettype none
// ============================================================================
// Module   : lcd_console
// Purpose  : Terminal-style text engine feeding the lcd_rgb character buffer.
//            Define LCD_CONSOLE_FIFO_EN to add a 4-entry DATA byte FIFO.
// Revision : 1.0
// ============================================================================
module lcd_console #(
  parameter int         COLUMNS   = 60,
  parameter int         ROWS      = 17,
  parameter logic [7:0] CHAR_BASE = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        lcd_select,
  output logic [3:0]  lcd_wstrb,
  output logic [9:0]  lcd_addr,
  output logic [31:0] lcd_data,
  input  logic        lcd_ready
);

  localparam int LINE_WORDS = COLUMNS / 4;
  localparam int ALL_WORDS  = COLUMNS * ROWS / 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_NEXT, ST_CLR_LINE, ST_CLR_ALL
  } state_t;

  typedef enum logic [1:0] {OP_CHAR, OP_BS, OP_LINE, OP_ALL} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  word_q, word_d;
  logic [9:0]  lcd_addr_q, lcd_addr_d;
  logic [3:0]  lcd_wstrb_q, lcd_wstrb_d;
  logic [31:0] lcd_data_q, lcd_data_d;
  logic        ready_q, ready_d;
  logic [31:0] data_o_q, data_o_d;

  logic       w_req, w_wr;
  logic       w_sel_data, w_sel_status, w_sel_ctrl, w_sel_cursor;
  logic       w_full, w_empty, w_data_ok;
  logic       w_cmd_valid;
  logic [7:0] w_cmd_byte;
  logic       w_busy, w_idle_all, w_accept, w_clr_cmd, w_cur_cmd;
  logic [9:0] w_row_base, w_cur_addr, w_bs_addr;
  logic [7:0] w_idx;
  logic       w_printable;
  logic [4:0] w_row_next;

  // ready_q blocks re-acceptance while the CPU still holds select after ready
  assign w_req        = select & ~ready_q;
  assign w_wr         = |wstrb;
  assign w_sel_data   = (addr[3:2] == 2'd0);
  assign w_sel_status = (addr[3:2] == 2'd1);
  assign w_sel_ctrl   = (addr[3:2] == 2'd2);
  assign w_sel_cursor = (addr[3:2] == 2'd3);

`ifdef LCD_CONSOLE_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;
  logic       w_push, w_pop;

  assign w_pop       = (state_q == ST_IDLE) && (count_q != 3'd0);
  assign w_full      = (count_q == 3'd4);
  assign w_empty     = (count_q == 3'd0);
  assign w_data_ok   = ~w_full | w_pop;
  assign w_push      = w_req & w_wr & w_sel_data & w_data_ok;
  assign w_cmd_valid = w_pop;
  assign w_cmd_byte  = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) fifo_mem[wr_ptr_q] <= data_i[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b0, w_push} - {2'b0, w_pop};
    end
  end
`else
  assign w_full      = 1'b0;
  assign w_empty     = 1'b1;
  assign w_data_ok   = (state_q == ST_IDLE);
  assign w_cmd_valid = w_req & w_wr & w_sel_data & w_data_ok;
  assign w_cmd_byte  = data_i[7:0];
`endif

  assign w_busy     = (state_q != ST_IDLE) | ~w_empty;
  assign w_idle_all = (state_q == ST_IDLE) & w_empty;
  assign w_accept   = ~w_wr | w_sel_status | (w_sel_data & w_data_ok) |
                      ((w_sel_ctrl | w_sel_cursor) & w_idle_all);
  assign ready_d    = w_req & w_accept;
  assign w_clr_cmd  = w_req & w_wr & w_sel_ctrl & data_i[0] & w_idle_all;
  assign w_cur_cmd  = w_req & w_wr & w_sel_cursor & w_idle_all &
                      (data_i[5:0] < 6'(COLUMNS)) & (data_i[20:16] < 5'(ROWS));

  assign w_row_base  = 10'(row_q) * 10'(COLUMNS);
  assign w_cur_addr  = w_row_base + 10'(col_q);
  assign w_bs_addr   = w_cur_addr - 10'd1;
  assign w_idx       = w_cmd_byte - CHAR_BASE;
  assign w_printable = (w_cmd_byte >= 8'h20) && (w_cmd_byte <= 8'h7E);
  assign w_row_next  = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  always_comb begin
    data_o_d = '0;
    if (w_req && !w_wr) begin
      if (w_sel_status) begin
        data_o_d[0]     = w_busy;
        data_o_d[1]     = w_full;
        data_o_d[13:8]  = col_q;
        data_o_d[20:16] = row_q;
      end else if (w_sel_cursor) begin
        data_o_d[5:0]   = col_q;
        data_o_d[20:16] = row_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    col_d       = col_q;
    row_d       = row_q;
    word_d      = word_q;
    lcd_addr_d  = lcd_addr_q;
    lcd_wstrb_d = lcd_wstrb_q;
    lcd_data_d  = lcd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_valid) begin
          if (w_printable) begin
            lcd_addr_d  = w_cur_addr;
            lcd_wstrb_d = 4'b0001 << w_cur_addr[1:0];
            lcd_data_d  = {4{1'b0, w_idx[6:0]}};
            op_d        = OP_CHAR;
            state_d     = ST_ISSUE;
          end else if (w_cmd_byte == 8'h0D) begin
            col_d = '0;
          end else if (w_cmd_byte == 8'h0A) begin
            col_d   = '0;
            row_d   = w_row_next;
            word_d  = '0;
            op_d    = OP_LINE;
            state_d = ST_CLR_LINE;
          end else if (w_cmd_byte == 8'h08 && col_q != 6'd0) begin
            col_d       = col_q - 6'd1;
            lcd_addr_d  = w_bs_addr;
            lcd_wstrb_d = 4'b0001 << w_bs_addr[1:0];
            lcd_data_d  = '0;
            op_d        = OP_BS;
            state_d     = ST_ISSUE;
          end
        end else if (w_clr_cmd) begin
          word_d  = '0;
          op_d    = OP_ALL;
          state_d = ST_CLR_ALL;
        end else if (w_cur_cmd) begin
          col_d = data_i[5:0];
          row_d = data_i[20:16];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lcd_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_CHAR: begin
            if (col_q == 6'(COLUMNS - 1)) begin
              col_d   = '0;
              row_d   = w_row_next;
              word_d  = '0;
              op_d    = OP_LINE;
              state_d = ST_CLR_LINE;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
          OP_LINE: begin
            if (word_q != 8'(LINE_WORDS - 1)) begin
              word_d  = word_q + 8'd1;
              state_d = ST_CLR_LINE;
            end
          end
          OP_ALL: begin
            if (word_q != 8'(ALL_WORDS - 1)) begin
              word_d  = word_q + 8'd1;
              state_d = ST_CLR_ALL;
            end else begin
              col_d = '0;
              row_d = '0;
            end
          end
          default: ;
        endcase
      end
      ST_CLR_LINE: begin
        lcd_addr_d  = w_row_base + {word_q, 2'b00};
        lcd_wstrb_d = 4'hF;
        lcd_data_d  = '0;
        state_d     = ST_ISSUE;
      end
      ST_CLR_ALL: begin
        lcd_addr_d  = {word_q, 2'b00};
        lcd_wstrb_d = 4'hF;
        lcd_data_d  = '0;
        state_d     = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLR_ALL;
      op_q        <= OP_ALL;
      col_q       <= '0;
      row_q       <= '0;
      word_q      <= '0;
      lcd_addr_q  <= '0;
      lcd_wstrb_q <= '0;
      lcd_data_q  <= '0;
      ready_q     <= 1'b0;
      data_o_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      col_q       <= col_d;
      row_q       <= row_d;
      word_q      <= word_d;
      lcd_addr_q  <= lcd_addr_d;
      lcd_wstrb_q <= lcd_wstrb_d;
      lcd_data_q  <= lcd_data_d;
      ready_q     <= ready_d;
      data_o_q    <= data_o_d;
    end
  end

  assign ready      = ready_q;
  assign data_o     = data_o_q;
  assign lcd_select = (state_q == ST_ISSUE);
  assign lcd_addr   = lcd_addr_q;
  assign lcd_wstrb  = lcd_wstrb_q;
  assign lcd_data   = lcd_data_q;

  logic w_unused;
  assign w_unused = &{1'b0, data_i[31:21], data_i[15:8], addr[1:0], w_idx[7]};

endmodule
`default_nettype wire

// File: tb/tb_lcd_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_console
// Purpose  : Scoreboard bench for lcd_console (queue of expected lcd writes).
// Revision : 1.0
// ============================================================================
module tb_lcd_console;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic        ready;
  logic [31:0] data_o;
  logic        lcd_select;
  logic [3:0]  lcd_wstrb;
  logic [9:0]  lcd_addr;
  logic [31:0] lcd_data;
  logic        lcd_ready = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_extra = 0;
  int   n_lcd   = 0;
  bit   hold_lcd = 1'b0;
  logic [45:0] exp_q [$];

  always #5 clk = ~clk;

  lcd_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .select     (select),
    .wstrb      (wstrb),
    .addr       (addr),
    .data_i     (data_i),
    .ready      (ready),
    .data_o     (data_o),
    .lcd_select (lcd_select),
    .lcd_wstrb  (lcd_wstrb),
    .lcd_addr   (lcd_addr),
    .lcd_data   (lcd_data),
    .lcd_ready  (lcd_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Screen-buffer model: ready one cycle after the select cycle unless held off
  initial forever begin
    @(negedge clk);
    if (lcd_select) begin
      @(negedge clk);
      while (hold_lcd) @(negedge clk);
      lcd_ready = 1'b1;
      @(negedge clk);
      lcd_ready = 1'b0;
    end
  end

  initial forever begin
    logic [45:0] e;
    @(negedge clk);
    if (reset_n && lcd_select) begin
      n_lcd++;
      if (exp_q.size() == 0) n_extra++;
      else begin
        e = exp_q.pop_front();
        check("lcd_write", {18'b0, lcd_addr, lcd_wstrb, lcd_data}, {18'b0, e});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_char(input int row, input int col, input logic [7:0] ch);
    logic [9:0] a;
    logic [7:0] idx;
    a   = 10'(row * 60 + col);
    idx = ch - 8'h20;
    exp_q.push_back({a, 4'b0001 << a[1:0], {4{idx}}});
  endtask

  task automatic push_clr(input int base, input int words);
    for (int k = 0; k < words; k++) exp_q.push_back({10'(base + 4 * k), 4'hF, 32'h0});
  endtask

  task automatic cpu_access(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output int cyc);
    @(negedge clk);
    addr = a; data_i = d; wstrb = s; select = 1'b1; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < 5000);
    check("cpu_ready", ready, 1);
    rd = data_o;
    select = 1'b0; wstrb = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    int c;
    cpu_access(a, d, 4'hF, r, c);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int c;
    cpu_access(a, 32'h0, 4'h0, r, c);
    check(tag, r, exp);
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    int c, i;
    i = 0;
    do begin
      cpu_access(4'h4, 32'h0, 4'h0, r, c);
      i++;
    end while (r[0] && i < 2000);
    check("idle", r[0], 0);
  endtask

  task automatic lcd_done(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_extra"}, n_extra, 0);
  endtask

  initial begin
    logic [31:0] r;
    int cyc, base;
    logic [7:0] stall_ch;

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_data_o", data_o, 0);
    check("rst_lcd_select", lcd_select, 0);
    check("rst_lcd_wstrb", lcd_wstrb, 0);
    check("rst_lcd_addr", lcd_addr, 0);
    check("rst_lcd_data", lcd_data, 0);
    push_clr(0, 255);
    reset_n = 1'b1;
    wait_idle();
    lcd_done("init_clear");
    rd_check("status_after_clear", 4'h4, 32'h0);

    push_char(0, 0, 8'h41); wr(4'h0, 32'h41);
    push_char(0, 1, 8'h42); wr(4'h0, 32'h42);
    wait_idle();
    lcd_done("chars");
    rd_check("status_col2", 4'h4, 32'h0000_0200);

    wr(4'hC, 32'h0010_003B);
    rd_check("cursor_rd", 4'hC, 32'h0010_003B);
    push_char(16, 59, 8'h41);
    push_clr(0, 15);
    wr(4'h0, 32'h41);
    wait_idle();
    lcd_done("wrap");
    rd_check("status_wrap", 4'h4, 32'h0);

    wr(4'hC, 32'h0002_0005);
    push_clr(180, 15);
    wr(4'h0, 32'h0D);
    wr(4'h0, 32'h0A);
    wait_idle();
    lcd_done("crlf");
    rd_check("status_crlf", 4'h4, 32'h0003_0000);
    wr(4'h0, 32'h08);
    wait_idle();
    lcd_done("bs_col0");
    rd_check("status_bs_col0", 4'h4, 32'h0003_0000);

    wr(4'hC, 32'h0001_0003);
    push_char(1, 2, 8'h20);
    wr(4'h0, 32'h08);
    wait_idle();
    rd_check("status_bs", 4'h4, 32'h0001_0200);
    push_char(1, 2, 8'h7E); wr(4'h0, 32'h7E);
    push_char(1, 3, 8'h20); wr(4'h0, 32'h20);
    wr(4'h0, 32'h7F);
    wr(4'h0, 32'h1F);
    wait_idle();
    lcd_done("bounds");
    rd_check("cursor_after_bounds", 4'hC, 32'h0001_0004);
    wr(4'hC, 32'h0000_003C);
    wr(4'hC, 32'h0011_0000);
    rd_check("cursor_invalid", 4'hC, 32'h0001_0004);
    rd_check("data_rd", 4'h0, 32'h0);
    rd_check("ctrl_rd", 4'h8, 32'h0);

    wr(4'hC, 32'h0005_0000);
    hold_lcd = 1'b1;
    push_char(5, 0, 8'h41);
    cpu_access(4'h0, 32'h41, 4'hF, r, cyc);
    check("first_accept_cyc", cyc, 1);
`ifdef LCD_CONSOLE_FIFO_EN
    for (int i = 1; i <= 4; i++) begin
      push_char(5, i, 8'(8'h41 + i));
      cpu_access(4'h0, 32'(8'h41 + i), 4'hF, r, cyc);
      check("fifo_no_stall", cyc, 1);
    end
    rd_check("status_full", 4'h4, 32'h0005_0003);
    stall_ch = 8'h46;
    push_char(5, 5, stall_ch);
`else
    rd_check("status_busy", 4'h4, 32'h0005_0001);
    stall_ch = 8'h42;
    push_char(5, 1, stall_ch);
`endif
    fork
      cpu_access(4'h0, 32'(stall_ch), 4'hF, r, cyc);
      begin
        repeat (20) @(negedge clk);
        hold_lcd = 1'b0;
      end
    join
    check("stall_cycles", cyc >= 20, 1);
    wait_idle();
    lcd_done("stall");
`ifdef LCD_CONSOLE_FIFO_EN
    rd_check("status_after_stall", 4'h4, 32'h0005_0600);
`else
    rd_check("status_after_stall", 4'h4, 32'h0005_0200);
`endif

    base = n_lcd;
    push_clr(0, 101);
    wr(4'h8, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_lcd - base >= 101) break;
    end
    check("reached_word100", n_lcd - base, 101);
    reset_n = 1'b0;
    #1;
    check("rst_abort_select", lcd_select, 0);
    lcd_done("abort");
    repeat (3) @(negedge clk);
    push_clr(0, 255);
    reset_n = 1'b1;
    wait_idle();
    lcd_done("restart_clear");
    rd_check("status_after_restart", 4'h4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
